// File: rtl/periph_bus_if.sv
// periph_bus_if: CPU-side request/ready bus plus peripheral-slot bus of periph_bus.
// Ports (by modport):
//   master : the environment; drives cpu_* requests and per_* slave responses
//   slave  : periph_bus itself; consumes requests, drives per_* strobes and cpu_* responses
// NUM_PORTS and SEL_LSB must match the parameters of the periph_bus instance.
interface periph_bus_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned SEL_LSB   = 12
);
    logic                    cpu_req_i;
    logic                    cpu_we_i;
    logic [31:0]             cpu_addr_i;
    logic [31:0]             cpu_wdata_i;
    logic [3:0]              cpu_wmask_i;
    logic [31:0]             cpu_rdata_o;
    logic                    cpu_ready_o;
    logic                    cpu_err_o;
    logic [NUM_PORTS-1:0]    per_sel_o;
    logic                    per_we_o;
    logic [SEL_LSB-1:0]      per_addr_o;
    logic [31:0]             per_wdata_o;
    logic [3:0]              per_wmask_o;
    logic [32*NUM_PORTS-1:0] per_rdata_i;
    logic [NUM_PORTS-1:0]    per_ready_i;

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_wmask_i,
        input  cpu_rdata_o, cpu_ready_o, cpu_err_o,
        input  per_sel_o, per_we_o, per_addr_o, per_wdata_o, per_wmask_o,
        output per_rdata_i, per_ready_i
    );

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_wmask_i,
        output cpu_rdata_o, cpu_ready_o, cpu_err_o,
        output per_sel_o, per_we_o, per_addr_o, per_wdata_o, per_wmask_o,
        input  per_rdata_i, per_ready_i
    );
endinterface

// File: rtl/periph_bus.sv
// periph_bus: registered request/ready interconnect for the 0x2xxx_xxxx window,
// serving NUM_PORTS peripheral slots selected by addr[SEL_LSB +: 4].
// Ports:
//   clk      : system clock, rising edge
//   reset_ni : synchronous active-low reset
//   bus      : periph_bus_if.slave (cpu_* request/response, per_* slot bus)
// Optional feature: define PERIPH_BUS_TIMEOUT_EN to end stalled accesses with an
// error after TIMEOUT_CYCLES wait cycles; otherwise ACCESS waits indefinitely.
module periph_bus #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned SEL_LSB        = 12,
    parameter logic [3:0]  BASE_NIBBLE    = 4'h2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input logic         clk,
    input logic         reset_ni,
    periph_bus_if.slave bus
);
    localparam int unsigned MAX_PORTS = 16;

    // Elaboration-time parameter range checks.
    if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("periph_bus: NUM_PORTS out of range 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("periph_bus: TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               r_state;
    logic [3:0]           r_slot;
    logic [NUM_PORTS-1:0] r_sel;
    logic                 r_we;
    logic [SEL_LSB-1:0]   r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wmask;
    logic [31:0]          r_rdata;
    logic                 r_ready;
    logic                 r_err;

    logic [3:0]           w_slot;
    logic                 w_hit;
    logic                 w_mapped;
    logic [MAX_PORTS-1:0] w_ready_all;
    logic [31:0]          w_rdata_all [MAX_PORTS];
    logic                 w_timeout;

    assign w_slot   = bus.cpu_addr_i[SEL_LSB +: 4];
    assign w_hit    = bus.cpu_req_i && (bus.cpu_addr_i[31:28] == BASE_NIBBLE);
    assign w_mapped = 5'(w_slot) < 5'(NUM_PORTS);

    // Widen slot vectors to 16 entries so the 4-bit slot index always fits.
    for (genvar k = 0; k < MAX_PORTS; k++) begin : g_slot
        if (k < NUM_PORTS) begin : g_used
            assign w_ready_all[k] = bus.per_ready_i[k];
            assign w_rdata_all[k] = bus.per_rdata_i[32*k +: 32];
        end else begin : g_unused
            assign w_ready_all[k] = 1'b0;
            assign w_rdata_all[k] = 32'd0;
        end
    end

`ifdef PERIPH_BUS_TIMEOUT_EN
    logic [15:0] r_cnt;
    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    // Control FSM with registered outputs; ready from the slot beats timeout.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_slot  <= 4'd0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_wmask <= 4'd0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
`ifdef PERIPH_BUS_TIMEOUT_EN
            r_cnt   <= 16'd0;
`endif
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_slot  <= w_slot;
                        r_we    <= bus.cpu_we_i;
                        r_addr  <= bus.cpu_addr_i[SEL_LSB-1:0];
                        r_wdata <= bus.cpu_wdata_i;
                        r_wmask <= bus.cpu_wmask_i;
                        if (w_mapped) begin
                            r_sel   <= NUM_PORTS'(MAX_PORTS'(1) << w_slot);
                            r_state <= ACCESS;
`ifdef PERIPH_BUS_TIMEOUT_EN
                            r_cnt   <= 16'd0;
`endif
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= ERR_DATA;
                            r_ready <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (w_ready_all[r_slot]) begin
                        r_rdata <= r_we ? 32'd0 : w_rdata_all[r_slot];
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_sel   <= '0;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_sel   <= '0;
                        r_state <= RESP;
                    end else begin
`ifdef PERIPH_BUS_TIMEOUT_EN
                        r_cnt   <= r_cnt + 16'd1;
`endif
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata_o = r_rdata;
    assign bus.cpu_ready_o = r_ready;
    assign bus.cpu_err_o   = r_err;
    assign bus.per_sel_o   = r_sel;
    assign bus.per_we_o    = r_we;
    assign bus.per_addr_o  = r_addr;
    assign bus.per_wdata_o = r_wdata;
    assign bus.per_wmask_o = r_wmask;
endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: randomized transactions against a transaction-level timing model.
module tb_periph_bus;
    localparam int unsigned NP  = 4;
    localparam int unsigned SEL = 12;
    localparam int unsigned TO  = 8;
`ifdef PERIPH_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic reset_ni;

    periph_bus_if #(.NUM_PORTS(NP), .SEL_LSB(SEL)) bus ();

    periph_bus #(.NUM_PORTS(NP), .SEL_LSB(SEL), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_ni(reset_ni),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit check_en   = 1'b0;
    bit rand_drop  = 1'b0;
    bit fix_en     = 1'b0;
    logic [31:0] fix_val = 32'd0;

    // Expected outputs after the next rising edge.
    logic [NP-1:0]  exp_sel = '0;
    logic           exp_we  = 1'b0;
    logic [SEL-1:0] exp_addr = '0;
    logic [31:0]    exp_wd  = 32'd0;
    logic [3:0]     exp_wm  = 4'd0;
    logic [31:0]    exp_rd  = 32'd0;
    logic           exp_rdy = 1'b0;
    logic           exp_err = 1'b0;

    logic [31:0] rd_w [NP];

    // Observed-behaviour trackers for literal checks.
    int sel_run = 0, last_run = 0, sel_start = 0;
    int last_rdy_cyc = 0, prev_rdy_cyc = 0;
    logic [NP-1:0] run_sel = '0;

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        cmp(n, a, e);
    endtask

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (check_en) begin
            vectors++;
            cmp("per_sel",   32'(bus.per_sel_o),   32'(exp_sel));
            cmp("per_we",    32'(bus.per_we_o),    32'(exp_we));
            cmp("per_addr",  32'(bus.per_addr_o),  32'(exp_addr));
            cmp("per_wdata", bus.per_wdata_o,      exp_wd);
            cmp("per_wmask", 32'(bus.per_wmask_o), 32'(exp_wm));
            cmp("cpu_ready", 32'(bus.cpu_ready_o), 32'(exp_rdy));
            cmp("cpu_err",   32'(bus.cpu_err_o),   32'(exp_err));
            cmp("cpu_rdata", bus.cpu_rdata_o,      exp_rd);
            if (bus.per_sel_o != '0) begin
                if (sel_run == 0) begin
                    sel_start = cyc;
                    run_sel   = bus.per_sel_o;
                end
                sel_run++;
            end else if (sel_run != 0) begin
                last_run = sel_run;
                sel_run  = 0;
            end
            if (bus.cpu_ready_o) begin
                prev_rdy_cyc = last_rdy_cyc;
                last_rdy_cyc = cyc;
            end
        end
    end

    task automatic drive_rd();
        for (int k = 0; k < NP; k++) bus.per_rdata_i[32*k +: 32] = rd_w[k];
    endtask

    task automatic idle(input int n, input bit foreign);
        logic [3:0] nb;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            nb = 4'($urandom);
            if (nb == 4'h2) nb = 4'h7;
            bus.cpu_req_i   = foreign;
            bus.cpu_addr_i  = {nb, 28'($urandom)};
            bus.per_ready_i = NP'($urandom);
            exp_rdy = 1'b0;
        end
    endtask

    // One transaction: slave ready after 'waits' ACCESS cycles; reset at ACCESS cycle rst_at.
    task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                       input logic [3:0] wm, input int waits, input int rst_at, input bit keep_req);
        int slot;
        bit mapped;
        bit done;
        logic [NP-1:0] oh;
        slot   = int'(addr[SEL +: 4]);
        mapped = (slot < NP);
        oh     = mapped ? (NP'(1) << slot) : '0;
        @(negedge clk);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        bus.cpu_wmask_i = wm;
        bus.per_ready_i = NP'($urandom);
        exp_we = we; exp_addr = addr[SEL-1:0]; exp_wd = wd; exp_wm = wm;
        if (!mapped) begin
            exp_sel = '0; exp_rdy = 1'b1; exp_err = 1'b1; exp_rd = 32'hDEAD_BEEF;
        end else begin
            exp_sel = oh; exp_rdy = 1'b0;
            done = 1'b0;
            for (int i = 0; !done && i < 200; i++) begin
                @(negedge clk);
                if (rand_drop) bus.cpu_req_i = 1'($urandom);
                for (int k = 0; k < NP; k++) rd_w[k] = $urandom;
                if (fix_en) rd_w[slot] = fix_val;
                drive_rd();
                bus.per_ready_i = (NP'($urandom) & ~oh) | ((i == waits) ? oh : '0);
                if (i == rst_at) begin
                    reset_ni = 1'b0;
                    exp_sel = '0; exp_we = 1'b0; exp_addr = '0; exp_wd = 32'd0;
                    exp_wm = 4'd0; exp_rd = 32'd0; exp_rdy = 1'b0; exp_err = 1'b0;
                    @(negedge clk);
                    reset_ni = 1'b1;
                    bus.cpu_req_i = 1'b0;
                    return;
                end
                if (i == waits) begin
                    exp_sel = '0; exp_rdy = 1'b1; exp_err = 1'b0;
                    exp_rd  = we ? 32'd0 : rd_w[slot];
                    done = 1'b1;
                end else if (TO_EN && i == int'(TO)) begin
                    exp_sel = '0; exp_rdy = 1'b1; exp_err = 1'b1; exp_rd = 32'hDEAD_BEEF;
                    done = 1'b1;
                end
            end
        end
        @(negedge clk);
        bus.cpu_req_i   = keep_req;
        bus.per_ready_i = NP'($urandom);
        exp_rdy = 1'b0;
    endtask

    initial begin
        int s, w, ra;
        logic [31:0] a;
        reset_ni = 1'b0;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'd0;
        bus.cpu_wdata_i = 32'd0; bus.cpu_wmask_i = 4'd0; bus.per_ready_i = '0;
        for (int k = 0; k < NP; k++) rd_w[k] = 32'd0;
        drive_rd();
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        reset_ni = 1'b1;
        chk("rst_rdata", bus.cpu_rdata_o, 32'd0);
        chk("rst_ready", 32'(bus.cpu_ready_o), 32'd0);
        chk("rst_sel",   32'(bus.per_sel_o), 32'd0);

        // Read slot 2, immediate ready.
        fix_en = 1'b1; fix_val = 32'h0000_0041;
        txn(32'h2000_2000, 1'b0, 32'd0, 4'd0, 0, -1, 1'b0);
        chk("rd2_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("rd2_rdata", bus.cpu_rdata_o, 32'h0000_0041);
        chk("rd2_err",   32'(bus.cpu_err_o), 32'd0);
        chk("rd2_sel",   32'(run_sel), 32'h4);
        chk("rd2_selrun", 32'(last_run), 32'd1);
        chk("rd2_lat",   32'(last_rdy_cyc - sel_start), 32'd1);
        fix_en = 1'b0;

        // Write slot 1 with three wait cycles.
        txn(32'h2000_1000, 1'b1, 32'h55, 4'hF, 3, -1, 1'b0);
        chk("wr_we",     32'(bus.per_we_o), 32'd1);
        chk("wr_wdata",  bus.per_wdata_o, 32'h55);
        chk("wr_addr",   32'(bus.per_addr_o), 32'd0);
        chk("wr_selrun", 32'(last_run), 32'd4);
        chk("wr_lat",    32'(last_rdy_cyc - sel_start), 32'd4);
        chk("wr_rdata",  bus.cpu_rdata_o, 32'd0);

        // Unmapped slots: first one past the end, and the last index.
        txn(32'h2000_4000, 1'b0, 32'd0, 4'd0, 0, -1, 1'b0);
        chk("um4_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("um4_err",   32'(bus.cpu_err_o), 32'd1);
        chk("um4_rdata", bus.cpu_rdata_o, 32'hDEAD_BEEF);
        txn(32'h2000_F000, 1'b1, 32'h1, 4'h1, 0, -1, 1'b0);
        chk("umF_err",   32'(bus.cpu_err_o), 32'd1);

        // Foreign-window requests are ignored.
        idle(5, 1'b1);

        // Back-to-back reads of slots 0 and 1 with req held.
        txn(32'h2000_0000, 1'b0, 32'd0, 4'd0, 0, -1, 1'b1);
        txn(32'h2000_1008, 1'b0, 32'd0, 4'd0, 0, -1, 1'b1);
        chk("b2b_gap", 32'(last_rdy_cyc - prev_rdy_cyc), 32'd3);
        idle(1, 1'b0);

        // Reset during ACCESS, then a normal access.
        txn(32'h2000_3000, 1'b0, 32'd0, 4'd0, 5, 2, 1'b0);
        chk("rst_mid_sel",   32'(bus.per_sel_o), 32'd0);
        chk("rst_mid_ready", 32'(bus.cpu_ready_o), 32'd0);
        txn(32'h2000_3004, 1'b1, 32'hA5A5_0001, 4'h3, 1, -1, 1'b0);
        chk("post_rst_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("post_rst_err",   32'(bus.cpu_err_o), 32'd0);

`ifdef PERIPH_BUS_TIMEOUT_EN
        // Slave never ready, then ready exactly on the timeout cycle.
        txn(32'h2000_3000, 1'b0, 32'd0, 4'd0, 50, -1, 1'b0);
        chk("to_selrun", 32'(last_run), 32'd9);
        chk("to_err",    32'(bus.cpu_err_o), 32'd1);
        chk("to_rdata",  bus.cpu_rdata_o, 32'hDEAD_BEEF);
        fix_en = 1'b1; fix_val = 32'h1234_5678;
        txn(32'h2000_3000, 1'b0, 32'd0, 4'd0, 8, -1, 1'b0);
        chk("tor_selrun", 32'(last_run), 32'd9);
        chk("tor_err",    32'(bus.cpu_err_o), 32'd0);
        chk("tor_rdata",  bus.cpu_rdata_o, 32'h1234_5678);
        fix_en = 1'b0;
`endif

        // Randomized traffic.
        rand_drop = 1'b1;
        repeat (250) begin
            s  = int'($urandom_range(0, 5));
            w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 2));
            ra = ($urandom_range(0, 24) == 0 && w > 0) ? int'($urandom_range(0, w - 1)) : -1;
            a  = {4'h2, 12'($urandom), 4'(s), 12'($urandom)};
            txn(a, 1'($urandom), $urandom, 4'($urandom), w, ra, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'($urandom));
        end
        idle(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
